// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer and its score display.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_ATTRACT    = 3'd0,
    ST_SERVE_WAIT = 3'd1,
    ST_PLAY       = 3'd2,
    ST_MISS       = 3'd3,
    ST_GAME_OVER  = 3'd4
  } state_t;

  localparam logic [1:0] SPEED_MAX = 2'd3;
  localparam logic [7:0] SCORE_MAX = 8'h99;

  // Two-digit BCD increment that sticks at SCORE_MAX.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v == SCORE_MAX) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/pong_bcd_score.sv
// Two-digit BCD score counter with synchronous clear and saturation at 99.
module pong_bcd_score
  import pong_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [7:0] o_score
);

  logic [7:0] r_score;

  // NOTE: non-blocking assignment keeps every register sampling pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) r_score <= 8'h00;
    else if (i_inc)       r_score <= bcd_inc(r_score);
  end

  assign o_score = r_score;

endmodule

// File: rtl/pong_match_controller.sv
// Match-level sequencer: game state, lives, BCD score and ball speed level,
// driven by frame/collision pulses from the datapath.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int LIVES          = 3,
  parameter int SERVE_FRAMES   = 60,
  parameter int MISS_FRAMES    = 63,
  parameter int HITS_PER_LEVEL = 8
) (
  input  logic       clk25,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic       hit,
  input  logic       miss,
  input  logic       start_btn,
  output logic       serve,
  output logic       freeze,
  output logic       miss_flash,
  output logic       game_over,
  output logic [1:0] speed,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int FRAME_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int FW        = $clog2(FRAME_MAX + 1);
  localparam int HW        = $clog2(HITS_PER_LEVEL + 1);

  localparam logic [FW-1:0] SERVE_LAST = FW'(SERVE_FRAMES - 1);
  localparam logic [FW-1:0] MISS_LAST  = FW'(MISS_FRAMES - 1);
  localparam logic [HW-1:0] HIT_LAST   = HW'(HITS_PER_LEVEL - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(LIVES);

  logic [1:0]    r_sync;
  logic          r_start_d;
  state_t        r_state;
  logic [FW-1:0] r_frame_cnt;
  logic [HW-1:0] r_hit_cnt;
  logic [1:0]    r_speed;
  logic [1:0]    r_lives;
  logic          r_serve;
  logic          r_freeze;
  logic          r_miss_flash;
  logic          r_game_over;

  logic w_start_p;
  logic w_new_game;
  logic w_score_inc;

  assign w_start_p   = r_sync[1] & ~r_start_d;
  assign w_new_game  = w_start_p & ((r_state == ST_ATTRACT) || (r_state == ST_GAME_OVER));
  // A miss in the same cycle as a hit discards the hit.
  assign w_score_inc = (r_state == ST_PLAY) & hit & ~miss;

  always_ff @(posedge clk25) begin
    if (Reset) begin
      r_sync       <= 2'b00;
      r_start_d    <= 1'b0;
      r_state      <= ST_ATTRACT;
      r_frame_cnt  <= '0;
      r_hit_cnt    <= '0;
      r_speed      <= 2'd0;
      r_lives      <= LIVES_INIT;
      r_serve      <= 1'b0;
      r_freeze     <= 1'b1;
      r_miss_flash <= 1'b0;
      r_game_over  <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], start_btn};
      r_start_d <= r_sync[1];
      r_serve   <= 1'b0;
      case (r_state)
        ST_ATTRACT, ST_GAME_OVER: begin
          if (w_new_game) begin
            r_lives     <= LIVES_INIT;
            r_speed     <= 2'd0;
            r_hit_cnt   <= '0;
            r_frame_cnt <= '0;
            r_serve     <= 1'b1;
            r_state     <= ST_SERVE_WAIT;
            r_game_over <= 1'b0;
          end
        end
        ST_SERVE_WAIT: begin
          if (frame_tick) begin
            if (r_frame_cnt == SERVE_LAST) begin
              r_frame_cnt <= '0;
              r_state     <= ST_PLAY;
              r_freeze    <= 1'b0;
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end
        ST_PLAY: begin
          if (miss) begin
            r_lives      <= r_lives - 2'd1;
            r_frame_cnt  <= '0;
            r_state      <= ST_MISS;
            r_freeze     <= 1'b1;
            r_miss_flash <= 1'b1;
          end else if (hit) begin
            if (r_hit_cnt == HIT_LAST) begin
              r_hit_cnt <= '0;
              if (r_speed != SPEED_MAX) r_speed <= r_speed + 2'd1;
            end else begin
              r_hit_cnt <= r_hit_cnt + HW'(1);
            end
          end
        end
        ST_MISS: begin
          if (frame_tick) begin
            if (r_frame_cnt == MISS_LAST) begin
              r_frame_cnt  <= '0;
              r_miss_flash <= 1'b0;
              if (r_lives == 2'd0) begin
                r_state     <= ST_GAME_OVER;
                r_game_over <= 1'b1;
              end else begin
                r_serve   <= 1'b1;
                r_speed   <= 2'd0;
                r_hit_cnt <= '0;
                r_state   <= ST_SERVE_WAIT;
              end
            end else begin
              r_frame_cnt <= r_frame_cnt + FW'(1);
            end
          end
        end
        default: begin
          r_state      <= ST_ATTRACT;
          r_freeze     <= 1'b1;
          r_miss_flash <= 1'b0;
          r_game_over  <= 1'b0;
        end
      endcase
    end
  end

  pong_bcd_score u_score (
    .i_clk   (clk25),
    .i_reset (Reset),
    .i_clr   (w_new_game),
    .i_inc   (w_score_inc),
    .o_score (score)
  );

  assign serve      = r_serve;
  assign freeze     = r_freeze;
  assign miss_flash = r_miss_flash;
  assign game_over  = r_game_over;
  assign speed      = r_speed;
  assign lives      = r_lives;
  assign state      = r_state;

endmodule

// File: tb/tb_pong_match_controller.sv
// Directed bench for pong_match_controller: serve timing, scoring, speed
// levels, miss/game-over sequencing and mid-game reset.
module tb_pong_match_controller;

  logic       clk25 = 1'b0;
  logic       Reset, frame_tick, hit, miss, start_btn;
  logic       serve, freeze, miss_flash, game_over;
  logic [1:0] speed, lives;
  logic [7:0] score;
  logic [2:0] state;

  int n_total = 0;
  int n_bad   = 0;

  always #20 clk25 = ~clk25;

  pong_match_controller dut (
    .clk25      (clk25),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .hit        (hit),
    .miss       (miss),
    .start_btn  (start_btn),
    .serve      (serve),
    .freeze     (freeze),
    .miss_flash (miss_flash),
    .game_over  (game_over),
    .speed      (speed),
    .score      (score),
    .lives      (lives),
    .state      (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk25);
    #1;
  endtask

  task automatic pulse_tick(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; step();
      frame_tick = 1'b0; step();
    end
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; step();
      hit = 1'b0; step();
    end
  endtask

  int first_serve;
  int n_serve;

  initial begin
    Reset = 1'b1; frame_tick = 1'b0; hit = 1'b0; miss = 1'b0; start_btn = 1'b0;
    step(); step();
    check("rst_state",  32'(state), 0);
    check("rst_freeze", 32'(freeze), 1);
    check("rst_serve",  32'(serve), 0);
    check("rst_lives",  32'(lives), 3);
    check("rst_score",  32'(score), 32'h00);
    check("rst_speed",  32'(speed), 0);
    check("rst_flash",  32'(miss_flash), 0);
    check("rst_gover",  32'(game_over), 0);
    Reset = 1'b0;
    step();

    // Button held 10 cycles; a frame tick lands on the serve (entry) edge.
    first_serve = 0; n_serve = 0;
    start_btn = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      frame_tick = (i == 3);
      step();
      if (serve) begin
        n_serve++;
        if (first_serve == 0) first_serve = i;
      end
    end
    frame_tick = 1'b0; start_btn = 1'b0;
    check("serve_latency", 32'(first_serve), 3);
    check("serve_count",   32'(n_serve), 1);
    check("start_state",   32'(state), 1);
    check("start_lives",   32'(lives), 3);
    check("start_score",   32'(score), 32'h00);
    check("start_freeze",  32'(freeze), 1);

    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0; step();
    check("ign_lives", 32'(lives), 3);
    check("ign_score", 32'(score), 32'h00);
    check("ign_state", 32'(state), 1);

    pulse_tick(59);
    check("sw59_state",  32'(state), 1);
    check("sw59_freeze", 32'(freeze), 1);
    pulse_tick(1);
    check("sw60_freeze", 32'(freeze), 0);
    check("sw60_state",  32'(state), 2);

    pulse_hit(8);
    check("h8_score", 32'(score), 32'h08);
    check("h8_speed", 32'(speed), 1);
    pulse_hit(4);
    check("h12_score", 32'(score), 32'h12);

    hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
    check("hm_score",  32'(score), 32'h12);
    check("hm_lives",  32'(lives), 2);
    check("hm_flash",  32'(miss_flash), 1);
    check("hm_freeze", 32'(freeze), 1);
    check("hm_state",  32'(state), 3);
    step();
    pulse_tick(62);
    check("miss62_state", 32'(state), 3);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("miss63_serve", 32'(serve), 1);
    check("miss63_speed", 32'(speed), 0);
    check("miss63_state", 32'(state), 1);
    check("miss63_flash", 32'(miss_flash), 0);
    step();
    check("miss63_serve_end", 32'(serve), 0);

    pulse_tick(60);
    check("play2_state", 32'(state), 2);
    pulse_hit(4);
    check("h16_score", 32'(score), 32'h16);
    check("hitcnt_cleared", 32'(speed), 0);
    pulse_hit(4);
    check("h20_score", 32'(score), 32'h20);
    check("h20_speed", 32'(speed), 1);
    pulse_hit(79);
    check("h99_score", 32'(score), 32'h99);
    check("h99_speed", 32'(speed), 3);
    pulse_hit(1);
    check("sat_score", 32'(score), 32'h99);
    check("sat_speed", 32'(speed), 3);

    miss = 1'b1; step(); miss = 1'b0;
    check("m2_lives", 32'(lives), 1);
    step();
    pulse_tick(63);
    check("m2_state", 32'(state), 1);
    pulse_tick(60);
    miss = 1'b1; step(); miss = 1'b0;
    check("m3_lives", 32'(lives), 0);
    check("m3_state", 32'(state), 3);
    step();
    pulse_tick(63);
    check("go_state", 32'(state), 4);
    check("go_flag",  32'(game_over), 1);
    check("go_score", 32'(score), 32'h99);
    check("go_serve", 32'(serve), 0);
    check("go_flash", 32'(miss_flash), 0);
    hit = 1'b1; step(); hit = 1'b0; step();
    check("go_hold_score", 32'(score), 32'h99);

    start_btn = 1'b1;
    step(); step(); step();
    check("ng_serve", 32'(serve), 1);
    check("ng_state", 32'(state), 1);
    check("ng_lives", 32'(lives), 3);
    check("ng_score", 32'(score), 32'h00);
    check("ng_gover", 32'(game_over), 0);
    start_btn = 1'b0;
    step();
    check("ng_serve_end", 32'(serve), 0);

    pulse_tick(60);
    miss = 1'b1; step(); miss = 1'b0; step();
    pulse_tick(30);
    check("pre_rst_state", 32'(state), 3);
    Reset = 1'b1; step();
    check("mr_state",  32'(state), 0);
    check("mr_flash",  32'(miss_flash), 0);
    check("mr_lives",  32'(lives), 3);
    check("mr_freeze", 32'(freeze), 1);
    Reset = 1'b0;
    n_serve = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      if (serve) n_serve++;
    end
    check("mr_no_serve", 32'(n_serve), 0);
    check("mr_idle",     32'(state), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
